// File: rtl/seg7_scan_decoder.sv
// Loopback checker for a multiplexed 4-digit active-low seven-segment display.
// Recovers the shown hex value and publishes it once it is stable over several frames.
module seg7_scan_decoder #(
    parameter int SETTLE       = 8,
    parameter int FRAMES_MATCH = 2,
    parameter int TIMEOUT      = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] value,
    output logic [3:0]  blank,
    output logic        valid,
    output logic        update,
    output logic        bad_pattern,
    output logic        bad_anode
);

    localparam logic [7:0]  SETTLE_C  = 8'(SETTLE);
    localparam logic [7:0]  SETTLE_M1 = 8'(SETTLE - 1);
    localparam logic [3:0]  MATCH_C   = 4'(FRAMES_MATCH);
    localparam logic [23:0] TIMEOUT_C = 24'(TIMEOUT);

    logic [3:0]  s_an_q, s_an_d, p_an_q, p_an_d;
    logic [6:0]  s_seg_q, s_seg_d, p_seg_q, p_seg_d;
    logic [7:0]  stable_q, stable_d;
    logic [3:0]  seen_q, seen_d;
    logic [15:0] buf_val_q, buf_val_d;
    logic [3:0]  buf_blank_q, buf_blank_d;
    logic [19:0] prev_frame_q, prev_frame_d;
    logic [3:0]  match_q, match_d;
    logic [23:0] to_q, to_d;
    logic        chk_q, chk_d;
    logic [15:0] value_q, value_d;
    logic [3:0]  blank_q, blank_d;
    logic        valid_q, valid_d;
    logic        update_q, update_d;
    logic        bad_pattern_q, bad_pattern_d;
    logic        bad_anode_q, bad_anode_d;

    logic [3:0]  dig_sel;
    logic [1:0]  dig_idx;
    logic        one_low, multi_low;
    logic        changed, capture, frame_done, expire;
    logic        glyph_ok, glyph_blank;
    logic [3:0]  glyph_nib;
    logic [19:0] frame_cur;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sel
            assign dig_sel[gi] = (s_an_q == ~(4'b0001 << gi));
        end
    endgenerate

    assign one_low   = |dig_sel;
    assign multi_low = (s_an_q != 4'hF) && !one_low;

    always_comb begin
        dig_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (dig_sel[i]) dig_idx = 2'(i);
        end
    end

    always_comb begin
        glyph_ok    = 1'b1;
        glyph_blank = 1'b0;
        glyph_nib   = 4'h0;
        case (s_seg_q)
            7'h40: glyph_nib = 4'h0;
            7'h79: glyph_nib = 4'h1;
            7'h24: glyph_nib = 4'h2;
            7'h30: glyph_nib = 4'h3;
            7'h19: glyph_nib = 4'h4;
            7'h12: glyph_nib = 4'h5;
            7'h02: glyph_nib = 4'h6;
            7'h78: glyph_nib = 4'h7;
            7'h00: glyph_nib = 4'h8;
            7'h10: glyph_nib = 4'h9;
            7'h08: glyph_nib = 4'hA;
            7'h03: glyph_nib = 4'hB;
            7'h46: glyph_nib = 4'hC;
            7'h21: glyph_nib = 4'hD;
            7'h06: glyph_nib = 4'hE;
            7'h0E: glyph_nib = 4'hF;
            7'h7F: glyph_blank = 1'b1;
            default: glyph_ok = 1'b0;
        endcase
    end

    assign changed    = {s_an_q, s_seg_q} != {p_an_q, p_seg_q};
    assign capture    = !changed && (stable_q == SETTLE_M1);
    assign frame_done = (seen_q == 4'hF);
    assign expire     = (to_q == 24'd1);
    assign frame_cur  = {buf_blank_q, buf_val_q};

    always_comb begin
        s_an_d        = an;
        s_seg_d       = seg;
        p_an_d        = s_an_q;
        p_seg_d       = s_seg_q;
        stable_d      = stable_q;
        seen_d        = seen_q;
        buf_val_d     = buf_val_q;
        buf_blank_d   = buf_blank_q;
        prev_frame_d  = prev_frame_q;
        match_d       = match_q;
        to_d          = to_q;
        chk_d         = 1'b0;
        value_d       = value_q;
        blank_d       = blank_q;
        valid_d       = valid_q;
        update_d      = 1'b0;
        bad_pattern_d = 1'b0;
        bad_anode_d   = 1'b0;

        if (changed) begin
            stable_d = 8'd0;
        end else if (stable_q != SETTLE_C) begin
            stable_d = stable_q + 8'd1;
        end

        if (to_q != 24'd0) to_d = to_q - 24'd1;
        if (expire && !frame_done) begin
            valid_d = 1'b0;
            match_d = 4'd0;
        end

        // Frame compare; the timeout reload here outranks a same-cycle expiry.
        if (frame_done) begin
            if (frame_cur == prev_frame_q) begin
                match_d = (match_q == MATCH_C) ? match_q : match_q + 4'd1;
            end else begin
                match_d = 4'd1;
            end
            prev_frame_d = frame_cur;
            seen_d       = 4'h0;
            to_d         = TIMEOUT_C;
            chk_d        = 1'b1;
        end

        if (capture) begin
            if (one_low) begin
                if (glyph_ok) begin
                    buf_val_d[{dig_idx, 2'b00} +: 4] = glyph_nib;
                    buf_blank_d[dig_idx]              = glyph_blank;
                    seen_d                            = seen_d | dig_sel;
                end else begin
                    bad_pattern_d = 1'b1;
                    seen_d        = 4'h0;
                    match_d       = 4'd0;
                end
            end else if (multi_low) begin
                bad_anode_d = 1'b1;
                seen_d      = 4'h0;
                match_d     = 4'd0;
            end
        end

        if (chk_q && (match_q == MATCH_C) &&
            ((prev_frame_q != {blank_q, value_q}) || !valid_q)) begin
            value_d  = prev_frame_q[15:0];
            blank_d  = prev_frame_q[19:16];
            valid_d  = 1'b1;
            update_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_an_q        <= 4'hF;
            s_seg_q       <= 7'h7F;
            p_an_q        <= 4'hF;
            p_seg_q       <= 7'h7F;
            stable_q      <= 8'd0;
            seen_q        <= 4'h0;
            buf_val_q     <= 16'h0;
            buf_blank_q   <= 4'h0;
            prev_frame_q  <= 20'h0;
            match_q       <= 4'd0;
            to_q          <= TIMEOUT_C;
            chk_q         <= 1'b0;
            value_q       <= 16'h0;
            blank_q       <= 4'h0;
            valid_q       <= 1'b0;
            update_q      <= 1'b0;
            bad_pattern_q <= 1'b0;
            bad_anode_q   <= 1'b0;
        end else begin
            s_an_q        <= s_an_d;
            s_seg_q       <= s_seg_d;
            p_an_q        <= p_an_d;
            p_seg_q       <= p_seg_d;
            stable_q      <= stable_d;
            seen_q        <= seen_d;
            buf_val_q     <= buf_val_d;
            buf_blank_q   <= buf_blank_d;
            prev_frame_q  <= prev_frame_d;
            match_q       <= match_d;
            to_q          <= to_d;
            chk_q         <= chk_d;
            value_q       <= value_d;
            blank_q       <= blank_d;
            valid_q       <= valid_d;
            update_q      <= update_d;
            bad_pattern_q <= bad_pattern_d;
            bad_anode_q   <= bad_anode_d;
        end
    end

    assign value       = value_q;
    assign blank       = blank_q;
    assign valid       = valid_q;
    assign update      = update_q;
    assign bad_pattern = bad_pattern_q;
    assign bad_anode   = bad_anode_q;

endmodule
